// File: rtl/nexi_uart_pkg.sv
// Shared definitions for the UART transmit path: data width and the
// feeder sequencer state encoding.
package nexi_uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/nexi_sync_fifo.sv
// Single-clock FIFO with registered level/full/empty flags and a
// combinational head read. A push into a full FIFO is accepted only when a
// pop happens in the same cycle. Pointers wrap naturally because DEPTH is a
// power of two.
module nexi_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          empty_next,
    output logic          push_ok
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic          full_r;
    logic          empty_r;
    logic [AW:0]   level_s;
    logic          pop_ok_s;
    logic          push_ok_s;

    // Accept/reject decisions and the next fill level.
    always_comb begin
        pop_ok_s  = pop & ~empty_r;
        push_ok_s = push & (~full_r | pop_ok_s);
        level_s   = level_r;
        if (push_ok_s && !pop_ok_s) begin
            level_s = level_r + (AW+1)'(1'b1);
        end else if (!push_ok_s && pop_ok_s) begin
            level_s = level_r - (AW+1)'(1'b1);
        end else begin
            level_s = level_r;
        end
    end

    // Storage array; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers, level and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            level_r <= level_s;
            full_r  <= (level_s == FULL_LVL);
            empty_r <= (level_s == '0);
        end
    end

    assign rdata      = mem_r[rd_ptr_r];
    assign level      = level_r;
    assign full       = full_r;
    assign empty      = empty_r;
    assign empty_next = (level_s == '0);
    assign push_ok    = push_ok_s;

endmodule

// File: rtl/nexi_uart_tx_feeder.sv
// Byte FIFO plus request sequencer in front of nexi_uart_tx. Bytes are
// offered one at a time on command_send/data; a byte is popped only once the
// transmitter acknowledges by dropping done_ack. A request that is never
// acknowledged is abandoned after REQ_TIMEOUT cycles and retried later.
module nexi_uart_tx_feeder
    import nexi_uart_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int REQ_TIMEOUT = 15
) (
    input  logic                   clk_1x_bps,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            level,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic                   tx_timeout,
    output logic                   busy,
    output logic                   tx_command_send,
    output logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_done_ack
);

    localparam int TW = $clog2(REQ_TIMEOUT);

    feeder_state_t          state_r;
    feeder_state_t          state_s;
    logic                   cmd_r;
    logic                   cmd_s;
    logic [UART_DATA_W-1:0] data_r;
    logic [UART_DATA_W-1:0] data_s;
    logic [TW-1:0]          timer_r;
    logic [TW-1:0]          timer_s;
    logic                   pop_s;
    logic                   timeout_set_s;
    logic                   ovf_r;
    logic                   ovf_s;
    logic                   tmo_r;
    logic                   tmo_s;
    logic                   busy_r;
    logic                   busy_s;

    logic [UART_DATA_W-1:0] head_s;
    logic [AW:0]            fifo_level_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic                   empty_next_s;
    logic                   push_ok_s;

    nexi_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (UART_DATA_W)
    ) u_fifo (
        .clk        (clk_1x_bps),
        .rst_n      (rst_n),
        .push       (wr_en),
        .wdata      (wr_data),
        .pop        (pop_s),
        .rdata      (head_s),
        .level      (fifo_level_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .empty_next (empty_next_s),
        .push_ok    (push_ok_s)
    );

    // Sequencer next state and next values of the registered tx outputs.
    always_comb begin
        state_s       = state_r;
        cmd_s         = cmd_r;
        data_s        = data_r;
        timer_s       = timer_r;
        pop_s         = 1'b0;
        timeout_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s && tx_done_ack) begin
                    state_s = ST_REQ;
                    cmd_s   = 1'b1;
                    data_s  = head_s;
                    timer_s = '0;
                end else begin
                    state_s = ST_IDLE;
                    cmd_s   = 1'b0;
                end
            end
            ST_REQ: begin
                if (!tx_done_ack) begin
                    // Transmitter took the byte: retire it from the FIFO.
                    pop_s   = 1'b1;
                    cmd_s   = 1'b0;
                    state_s = ST_DRAIN;
                end else if (timer_r == TW'(REQ_TIMEOUT - 1)) begin
                    // Give up; the head stays queued for a later retry.
                    cmd_s         = 1'b0;
                    timeout_set_s = 1'b1;
                    state_s       = ST_DRAIN;
                end else begin
                    timer_s = timer_r + TW'(1'b1);
                end
            end
            ST_DRAIN: begin
                if (tx_done_ack) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cmd_s   = 1'b0;
                timer_s = '0;
            end
        endcase
    end

    // Sticky status flags (set wins over clear) and the next busy value.
    always_comb begin
        if (wr_en && !push_ok_s) begin
            ovf_s = 1'b1;
        end else if (ovf_clr) begin
            ovf_s = 1'b0;
        end else begin
            ovf_s = ovf_r;
        end
        if (timeout_set_s) begin
            tmo_s = 1'b1;
        end else if (ovf_clr) begin
            tmo_s = 1'b0;
        end else begin
            tmo_s = tmo_r;
        end
        busy_s = (state_s != ST_IDLE) || !empty_next_s;
    end

    // Sequencer state, tx request outputs and status registers.
    always_ff @(posedge clk_1x_bps or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cmd_r   <= 1'b0;
            data_r  <= 8'h00;
            timer_r <= '0;
            ovf_r   <= 1'b0;
            tmo_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cmd_r   <= cmd_s;
            data_r  <= data_s;
            timer_r <= timer_s;
            ovf_r   <= ovf_s;
            tmo_r   <= tmo_s;
            busy_r  <= busy_s;
        end
    end

    assign tx_command_send = cmd_r;
    assign tx_data         = data_r;
    assign overflow        = ovf_r;
    assign tx_timeout      = tmo_r;
    assign busy            = busy_r;
    assign full            = fifo_full_s;
    assign empty           = fifo_empty_s;
    assign level           = fifo_level_s;

endmodule

// File: tb/tb_nexi_uart_tx_feeder.sv
// Bench for nexi_uart_tx_feeder. A behavioural transmitter model answers the
// command_send/done_ack handshake and serialises accepted bytes on tx_pin;
// a monitor decodes tx_pin and checks each byte against a queue of bytes the
// host pushed and the FIFO should have accepted.
module tb_nexi_uart_tx_feeder;

    logic       clk_1x_bps = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       ovf_clr;
    logic       tx_timeout;
    logic       busy;
    logic       tx_command_send;
    logic [7:0] tx_data;
    logic       tx_done_ack;

    // Transmitter model: mode 0 normal, 1 held busy (ack=0), 2 stuck idle (ack=1, ignores requests)
    int         mode;
    logic       stub_rst;
    logic       ack_r;
    logic       s1;
    logic       s2;
    logic       tx_pin;
    logic [9:0] tsh;
    int         tcnt;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];

    nexi_uart_tx_feeder #(.DEPTH(16), .AW(4), .REQ_TIMEOUT(15)) dut (
        .clk_1x_bps      (clk_1x_bps),
        .rst_n           (rst_n),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .full            (full),
        .empty           (empty),
        .level           (level),
        .overflow        (overflow),
        .ovf_clr         (ovf_clr),
        .tx_timeout      (tx_timeout),
        .busy            (busy),
        .tx_command_send (tx_command_send),
        .tx_data         (tx_data),
        .tx_done_ack     (tx_done_ack)
    );

    always #5 clk_1x_bps = ~clk_1x_bps;

    assign tx_done_ack = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : ack_r;

    // Transmitter model: 2-flop command sync, 10-bit frame LSB first, ack high when idle.
    always @(posedge clk_1x_bps) begin
        if (stub_rst) begin
            ack_r  <= 1'b1;
            s1     <= 1'b0;
            s2     <= 1'b0;
            tcnt   <= 0;
            tx_pin <= 1'b1;
            tsh    <= 10'h3ff;
        end else begin
            s1 <= tx_command_send;
            s2 <= s1;
            if (tcnt != 0) begin
                tx_pin <= tsh[0];
                tsh    <= tsh >> 1;
                tcnt   <= tcnt - 1;
            end else if (!ack_r) begin
                ack_r <= 1'b1;
            end else if (s2 && mode == 0) begin
                tsh   <= {1'b1, tx_data, 1'b0};
                tcnt  <= 10;
                ack_r <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Decodes frames from tx_pin and scores each byte against the expected queue.
    task mon_loop();
        bit         in_frame;
        int         bitn;
        logic [7:0] rx;
        logic [7:0] e;
        in_frame = 1'b0;
        bitn     = 0;
        rx       = 8'h00;
        forever begin
            @(negedge clk_1x_bps);
            if (!rst_n || stub_rst) begin
                in_frame = 1'b0;
            end else if (!in_frame) begin
                if (tx_pin == 1'b0) begin
                    in_frame = 1'b1;
                    bitn     = 1;
                end
            end else if (bitn <= 8) begin
                rx[bitn-1] = tx_pin;
                bitn++;
            end else begin
                in_frame = 1'b0;
                chk("stop_bit", {31'd0, tx_pin}, 32'd1);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got %0h, expected no byte", rx);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", {24'd0, rx}, {24'd0, e});
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_1x_bps);
        #1;
    endtask

    task automatic drive_push(input logic [7:0] b, input bit accept);
        wr_en   = 1'b1;
        wr_data = b;
        if (accept) exp_q.push_back(b);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_clr();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
    endtask

    task automatic wait_cmd(input string name, input int budget);
        int k = 0;
        while (!tx_command_send && k < budget) begin
            tick();
            k++;
        end
        chk({name, "_cmd_wait"}, {31'd0, tx_command_send}, 32'd1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (!(busy == 1'b0 && exp_q.size() == 0 && tx_done_ack == 1'b1) && k < budget) begin
            tick();
            k++;
        end
        chk({name, "_drain_done"}, {31'd0, (k < budget)}, 32'd1);
    endtask

    task automatic check_reset(input string name);
        chk({name, "_cmd"},   {31'd0, tx_command_send}, 32'd0);
        chk({name, "_data"},  {24'd0, tx_data}, 32'd0);
        chk({name, "_full"},  {31'd0, full}, 32'd0);
        chk({name, "_empty"}, {31'd0, empty}, 32'd1);
        chk({name, "_level"}, {27'd0, level}, 32'd0);
        chk({name, "_ovf"},   {31'd0, overflow}, 32'd0);
        chk({name, "_tmo"},   {31'd0, tx_timeout}, 32'd0);
        chk({name, "_busy"},  {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        int         cnt;
        int         k;
        int         n;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        ovf_clr  = 1'b0;
        mode     = 0;
        stub_rst = 1'b1;
        rst_n    = 1'b0;
        fork
            mon_loop();
        join_none

        // Power-on reset values
        repeat (2) tick();
        check_reset("por");
        rst_n    = 1'b1;
        stub_rst = 1'b0;
        tick();

        // Single byte: command 2 edges after push, pop drains level, busy clears
        drive_push(8'hA5, 1'b1);
        chk("a5_level1", {27'd0, level}, 32'd1);
        chk("a5_cmd_edge1", {31'd0, tx_command_send}, 32'd0);
        tick();
        chk("a5_cmd_edge2", {31'd0, tx_command_send}, 32'd1);
        chk("a5_data", {24'd0, tx_data}, 32'hA5);
        chk("a5_busy", {31'd0, busy}, 32'd1);
        k = 0;
        while (tx_command_send && k < 20) begin
            tick();
            k++;
        end
        chk("a5_level_after_pop", {27'd0, level}, 32'd0);
        wait_drain("a5", 100);

        // Sixteen bytes with tx held busy: exactly full, no overflow, then in-order drain
        mode = 1;
        for (int i = 0; i < 16; i++) drive_push(i[7:0], 1'b1);
        chk("fill_level", {27'd0, level}, 32'd16);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_ovf", {31'd0, overflow}, 32'd0);
        mode = 0;
        wait_drain("fill", 600);
        chk("fill_empty", {31'd0, empty}, 32'd1);

        // Seventeen pushes while held: last dropped, overflow sticky, then push+pop at full
        mode = 1;
        for (int i = 0; i < 17; i++) drive_push(8'($urandom_range(0, 255)), (i < 16));
        chk("ovf_level", {27'd0, level}, 32'd16);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        pulse_clr();
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);
        mode = 0;
        k = 0;
        while (!(tx_command_send && !tx_done_ack) && k < 20) begin
            tick();
            k++;
        end
        chk("pp_ack_seen", {31'd0, (k < 20)}, 32'd1);
        drive_push(8'($urandom_range(0, 255)), 1'b1);
        chk("pp_level", {27'd0, level}, 32'd16);
        chk("pp_ovf", {31'd0, overflow}, 32'd0);
        wait_drain("pp", 800);

        // Request never acknowledged: abort after 15 cycles, byte kept, retried later
        mode = 2;
        b = 8'($urandom_range(0, 255));
        drive_push(b, 1'b1);
        wait_cmd("tmo", 10);
        cnt = 1;
        k = 0;
        while (k < 40) begin
            tick();
            k++;
            if (tx_command_send) cnt++;
            else break;
        end
        chk("tmo_cycles", cnt, 32'd15);
        chk("tmo_flag", {31'd0, tx_timeout}, 32'd1);
        chk("tmo_level", {27'd0, level}, 32'd1);
        wait_cmd("tmo_retry", 10);
        chk("tmo_retry_data", {24'd0, tx_data}, {24'd0, b});
        mode = 0;
        wait_drain("tmo", 100);
        chk("tmo_sticky", {31'd0, tx_timeout}, 32'd1);
        pulse_clr();
        chk("tmo_cleared", {31'd0, tx_timeout}, 32'd0);

        // Transmitter reset during DRAIN: popped byte lost, next byte issued normally
        drive_push(8'($urandom_range(0, 255)), 1'b1);
        drive_push(8'($urandom_range(0, 255)), 1'b1);
        k = 0;
        while (!(!tx_command_send && !tx_done_ack && busy) && k < 30) begin
            tick();
            k++;
        end
        chk("drn_reached", {31'd0, (k < 30)}, 32'd1);
        repeat (2) tick();
        stub_rst = 1'b1;
        void'(exp_q.pop_front());
        tick();
        stub_rst = 1'b0;
        tick();
        chk("drn_idle_cmd", {31'd0, tx_command_send}, 32'd0);
        tick();
        chk("drn_next_cmd", {31'd0, tx_command_send}, 32'd1);
        wait_drain("drn", 100);

        // Randomised bursts with random gaps
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(4, 14);
            for (int i = 0; i < n; i++) begin
                drive_push(8'($urandom_range(0, 255)), 1'b1);
                repeat ($urandom_range(0, 3)) tick();
            end
            wait_drain("rnd", 600);
        end

        // Asynchronous reset mid-frame: everything back to reset values at once
        for (int i = 0; i < 3; i++) drive_push(8'($urandom_range(0, 255)), 1'b1);
        k = 0;
        while (tx_done_ack && k < 30) begin
            tick();
            k++;
        end
        @(posedge clk_1x_bps);
        #3;
        rst_n    = 1'b0;
        stub_rst = 1'b1;
        exp_q.delete();
        #1;
        check_reset("mid");
        repeat (2) tick();
        rst_n    = 1'b1;
        stub_rst = 1'b0;
        repeat (60) tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_pending", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
